button_sync_bank: RTL and testbench

BUTTON_SYNC_BANK -- requirements
Module: button_sync_bank

---
 rtl/button_sync_bank.sv | 137 +++++++++++++
 tb/tb_button_sync_bank.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_sync_bank.sv
// ============================================================================
// Module   : button_sync_bank
// Brief    : N-channel button synchroniser, debouncer and one-cycle press pulse
//            generator. Auto-repeat is built only with BUTTON_SYNC_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_sync_bank #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 0,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 250
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] Bis,
    output logic [N-1:0] Bo,
    output logic [N-1:0] Bl
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_S_IDLE = 2'b00;
    localparam logic [1:0] c_S_FIRE = 2'b01;
    localparam logic [1:0] c_S_HELD = 2'b10;

`ifdef BUTTON_SYNC_REPEAT_EN
    localparam int c_TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX);
    localparam logic [c_TMR_W-1:0] c_HOLD_LAST = c_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_REP_LAST  = c_TMR_W'(REPEAT_CYCLES - 1);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(HOLD_CYCLES), 32'(REPEAT_CYCLES)};
`endif

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic               w_norm;
        logic               r_sync1;
        logic               r_sync2;
        logic [c_CNT_W-1:0] r_cnt;
        logic [1:0]         r_state;
        logic [1:0]         w_next;
        logic               w_level;
        logic               w_toggle;
        logic               w_rise;
        logic               w_fall;
        logic               w_expire;

        // Normalise before synchronising so "not pressed" is always 0.
        assign w_norm = (ACTIVE_LOW != 0) ? ~Bis[g] : Bis[g];

        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= w_norm;
                r_sync2 <= r_sync1;
            end
        end

        // The debounced level is the FSM's pressed-ness, so it cannot drift from Bl.
        assign w_level  = (r_state == c_S_FIRE) || (r_state == c_S_HELD);
        assign w_toggle = (r_sync2 != w_level) && (r_cnt == c_CNT_LAST);
        assign w_rise   = w_toggle && !w_level;
        assign w_fall   = w_toggle && w_level;

        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_cnt <= '0;
            end else if ((r_sync2 == w_level) || w_toggle) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end

`ifdef BUTTON_SYNC_REPEAT_EN
        logic [c_TMR_W-1:0] r_tmr;
        logic               r_rep;

        // r_rep selects the repeat interval once the first auto-repeat has fired.
        assign w_expire = (r_state == c_S_HELD) &&
                          (r_tmr == (r_rep ? c_REP_LAST : c_HOLD_LAST));

        always_ff @(posedge Clk) begin
            if (Reset || (w_next == c_S_IDLE)) begin
                r_tmr <= '0;
                r_rep <= 1'b0;
            end else if (w_next == c_S_FIRE) begin
                r_tmr <= '0;
                r_rep <= (r_state == c_S_HELD);
            end else begin
                r_tmr <= r_tmr + c_TMR_W'(1);
            end
        end
`else
        assign w_expire = 1'b0;
`endif

        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_state <= c_S_IDLE;
            end else begin
                r_state <= w_next;
            end
        end

        always_comb begin
            w_next = c_S_IDLE;
            case (r_state)
                c_S_IDLE: w_next = w_rise ? c_S_FIRE : c_S_IDLE;
                c_S_FIRE: w_next = w_fall ? c_S_IDLE : c_S_HELD;
                c_S_HELD: begin
                    if (w_fall) begin
                        w_next = c_S_IDLE;
                    end else if (w_expire) begin
                        w_next = c_S_FIRE;
                    end else begin
                        w_next = c_S_HELD;
                    end
                end
                default:  w_next = c_S_IDLE;
            endcase
        end

        assign Bo[g] = (r_state == c_S_FIRE);
        assign Bl[g] = w_level;
    end

endmodule

`default_nettype wire

// File: tb/tb_button_sync_bank.sv
// ============================================================================
// Module   : tb_button_sync_bank
// Brief    : Scoreboard bench for button_sync_bank (N=4, debounce 4) plus a
//            single-channel active-low instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_sync_bank;

    localparam int D   = 4;
    localparam int HLD = 20;
    localparam int REP = 8;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bis;
    logic [3:0] bo;
    logic [3:0] bl;
    logic [0:0] bis_al;
    logic [0:0] bo_al;
    logic [0:0] bl_al;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    exp_t q_main[$];
    int   q_al[$];

    button_sync_bank #(
        .N(4), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0),
        .HOLD_CYCLES(HLD), .REPEAT_CYCLES(REP)
    ) u_dut (
        .Clk(clk), .Reset(rst), .Bis(bis), .Bo(bo), .Bl(bl)
    );

    button_sync_bank #(
        .N(1), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1),
        .HOLD_CYCLES(HLD), .REPEAT_CYCLES(REP)
    ) u_dut_al (
        .Clk(clk), .Reset(rst), .Bis(bis_al), .Bo(bo_al), .Bl(bl_al)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance one cycle; any Bo activity is matched against the scoreboard.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (mon_en && (bo !== 4'b0000)) begin
            n_tests++;
            if (q_main.size() == 0) begin
                n_fail++;
                $display("FAIL bo_pulse: cycle %0d bo=%b, required no pulse", cyc, bo);
            end else begin
                exp_t e;
                e = q_main.pop_front();
                if ((e.cyc != cyc) || (e.mask !== bo)) begin
                    n_fail++;
                    $display("FAIL bo_pulse: cycle %0d bo=%b, required cycle %0d bo=%b",
                             cyc, bo, e.cyc, e.mask);
                end
            end
        end
        if (mon_en && (bo_al !== 1'b0)) begin
            n_tests++;
            if (q_al.size() == 0) begin
                n_fail++;
                $display("FAIL bo_al_pulse: cycle %0d bo_al=%b, required no pulse", cyc, bo_al);
            end else begin
                int t;
                t = q_al.pop_front();
                if (t != cyc) begin
                    n_fail++;
                    $display("FAIL bo_al_pulse: pulse at cycle %0d, required cycle %0d", cyc, t);
                end
            end
        end
    endtask

    task automatic step_to(input int t);
        for (int i = 0; (i < 2000) && (cyc < t); i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bis = 4'b0000;
        bis_al = 1'b1;
        repeat (3) step();
        mon_en = 1'b1;
        n_tests++;
        if ((bo !== 4'b0000) || (bl !== 4'b0000)) begin
            n_fail++;
            $display("FAIL reset_main: bo=%b bl=%b, required 0000 0000", bo, bl);
        end
        n_tests++;
        if ((bo_al !== 1'b0) || (bl_al !== 1'b0)) begin
            n_fail++;
            $display("FAIL reset_al: bo=%b bl=%b, required 0 0", bo_al, bl_al);
        end
        rst = 1'b0;
        repeat (10) step();
        n_tests++;
        if (bl !== 4'b0000 || bl_al !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: bl=%b bl_al=%b, required 0000 0", bl, bl_al);
        end
    endtask

    task automatic test_single_press();
        int k, fire, fall;
        exp_t e;
        k    = cyc + 1;
        fire = k + 1 + D;
        fall = k + 60 + 1 + D;
        bis[0] = 1'b1;
        e.mask = 4'b0001;
        e.cyc  = fire;
        q_main.push_back(e);
`ifdef BUTTON_SYNC_REPEAT_EN
        for (int t = fire + HLD; t < fall; t += REP) begin
            e.cyc = t;
            q_main.push_back(e);
        end
`endif
        step_to(fire - 1);
        n_tests++;
        if (bl[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL press_latency_early: cycle %0d bl0=%b, required 0", cyc, bl[0]);
        end
        step();
        n_tests++;
        if (bl[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL press_latency: cycle %0d bl0=%b, required 1", cyc, bl[0]);
        end
        step_to(k + 59);
        bis[0] = 1'b0;
        step_to(fall - 1);
        n_tests++;
        if (bl[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL release_early: cycle %0d bl0=%b, required 1", cyc, bl[0]);
        end
        step();
        n_tests++;
        if (bl[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL release_latency: cycle %0d bl0=%b, required 0", cyc, bl[0]);
        end
        repeat (12) step();
        n_tests++;
        if (q_main.size() != 0) begin
            n_fail++;
            $display("FAIL single_drain: %0d pulses missing, required 0", q_main.size());
            q_main.delete();
        end
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        bis[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); seen |= bl[1]; end
        bis[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); seen |= bl[1]; end
        bis[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); seen |= bl[1]; end
        bis[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); seen |= bl[1]; end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_level: bl1 seen=%b, required 0", seen);
        end
        n_tests++;
        if (q_main.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_drain: %0d pulses pending, required 0", q_main.size());
            q_main.delete();
        end
    endtask

    task automatic test_simultaneous();
        int k;
        exp_t e;
        k = cyc + 1;
        bis = 4'b1010;
        e.cyc  = k + 1 + D;
        e.mask = 4'b1010;
        q_main.push_back(e);
        step_to(k + 1 + D);
        n_tests++;
        if (bl !== 4'b1010) begin
            n_fail++;
            $display("FAIL simul_level: bl=%b, required 1010", bl);
        end
        step_to(k + 11);
        bis = 4'b0000;
        step_to(k + 12 + 1 + D);
        n_tests++;
        if (bl !== 4'b0000) begin
            n_fail++;
            $display("FAIL simul_release: bl=%b, required 0000", bl);
        end
        repeat (4) step();
        n_tests++;
        if (q_main.size() != 0) begin
            n_fail++;
            $display("FAIL simul_drain: %0d pulses missing, required 0", q_main.size());
            q_main.delete();
        end
    endtask

    task automatic test_reset_mid_press();
        int k, r;
        exp_t e;
        k = cyc + 1;
        bis[2] = 1'b1;
        step_to(k + 1);
        rst = 1'b1;
        step_to(k + 6);
        n_tests++;
        if (bl !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_abort_level: bl=%b, required 0000", bl);
        end
        rst = 1'b0;
        r = k + 7;
        e.cyc  = r + 1 + D;
        e.mask = 4'b0100;
        q_main.push_back(e);
        step_to(r + 1 + D);
        n_tests++;
        if (bl !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_repress_level: bl=%b, required 0100", bl);
        end
        bis[2] = 1'b0;
        step_to(r + 6 + 1 + D);
        n_tests++;
        if (bl !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: bl=%b, required 0000", bl);
        end
        repeat (3) step();
        n_tests++;
        if (q_main.size() != 0) begin
            n_fail++;
            $display("FAIL reset_drain: %0d pulses missing, required 0", q_main.size());
            q_main.delete();
        end
    endtask

    task automatic test_back_to_back();
        int k;
        exp_t e;
        k = cyc + 1;
        bis[0] = 1'b1;
        e.cyc = k + 1 + D;     e.mask = 4'b0001; q_main.push_back(e);
        e.cyc = k + 3 + D;     e.mask = 4'b1000; q_main.push_back(e);
        e.cyc = k + 17 + D;    e.mask = 4'b0001; q_main.push_back(e);
        step_to(k + 1);
        bis[3] = 1'b1;
        step_to(k + 3 + D);
        n_tests++;
        if (bl !== 4'b1001) begin
            n_fail++;
            $display("FAIL b2b_level: bl=%b, required 1001", bl);
        end
        step_to(k + 7);
        bis = 4'b0000;
        step_to(k + 15);
        bis[0] = 1'b1;
        step_to(k + 25);
        bis[0] = 1'b0;
        step_to(k + 26 + 1 + D);
        n_tests++;
        if (bl !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_release: bl=%b, required 0000", bl);
        end
        repeat (3) step();
        n_tests++;
        if (q_main.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d pulses missing, required 0", q_main.size());
            q_main.delete();
        end
    endtask

    task automatic test_active_low();
        int k;
        k = cyc + 1;
        bis_al = 1'b0;
        q_al.push_back(k + 1 + D);
        step_to(k + D);
        n_tests++;
        if (bl_al !== 1'b0) begin
            n_fail++;
            $display("FAIL al_early: bl_al=%b, required 0", bl_al);
        end
        step();
        n_tests++;
        if (bl_al !== 1'b1) begin
            n_fail++;
            $display("FAIL al_level: bl_al=%b, required 1", bl_al);
        end
        step_to(k + 9);
        bis_al = 1'b1;
        step_to(k + 10 + 1 + D);
        n_tests++;
        if (bl_al !== 1'b0) begin
            n_fail++;
            $display("FAIL al_release: bl_al=%b, required 0", bl_al);
        end
        repeat (5) step();
        n_tests++;
        if (q_al.size() != 0) begin
            n_fail++;
            $display("FAIL al_drain: %0d pulses missing, required 0", q_al.size());
            q_al.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        bis = 4'b0000;
        bis_al = 1'b1;
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_reset_mid_press();
        test_back_to_back();
        test_active_low();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
